writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 147 ++++++++++++++
 tb/tb_writeback_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Captures one instruction per cycle
// from MEM, selects and extends the load or ALU result, and drives a one-cycle
// register file write pulse on the following cycle. It also flags misaligned
// loads and counts retired instructions.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> combinational forwarding port mirrors the write being captured
//   undefined -> bypassValid/bypassAddr/bypassData tied to 0
//
// Handshake: an instruction transfers on a rising edge where inValid=1 and
// inReady=1 (inReady = !stall). inValid may drop at any time without a
// transfer; a flushed transfer is consumed but produces no write, no alignErr
// and no retirement.
module writeback_stage (
    input  logic        clk,
    input  logic        rstN,
    input  logic        inValid,
    output logic        inReady,
    input  logic        stall,
    input  logic        flush,
    input  logic        inRegWrite,
    input  logic [4:0]  inRegAddr,
    input  logic        inMemToReg,
    input  logic [31:0] inAluResult,
    input  logic [31:0] inMemData,
    input  logic [1:0]  inLoadSize,
    input  logic        inLoadUnsigned,
    output logic        writeEn,
    output logic [4:0]  writeAddr,
    output logic [31:0] writeData,
    output logic        alignErr,
    output logic [31:0] retiredCount,
    output logic        bypassValid,
    output logic [4:0]  bypassAddr,
    output logic [31:0] bypassData
);

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    logic        capture;
    logic        misaligned;
    logic        write_ok;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] result;

    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        align_q, align_d;
    logic [31:0] retired_q, retired_d;

    assign inReady = !stall;
    assign capture = inValid && !stall;

    // Result selection: pick the addressed lane and extend it for sub-word loads.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        result    = inAluResult;
        case (inAluResult[1:0])
            2'd0:    byte_lane = inMemData[7:0];
            2'd1:    byte_lane = inMemData[15:8];
            2'd2:    byte_lane = inMemData[23:16];
            default: byte_lane = inMemData[31:24];
        endcase
        half_lane = inAluResult[1] ? inMemData[31:16] : inMemData[15:0];
        if (inMemToReg) begin
            case (inLoadSize)
                SIZE_BYTE: result = inLoadUnsigned ? {24'h0, byte_lane}
                                                   : {{24{byte_lane[7]}}, byte_lane};
                SIZE_HALF: result = inLoadUnsigned ? {16'h0, half_lane}
                                                   : {{16{half_lane[15]}}, half_lane};
                // Word and the reserved encoding both return the full word.
                default:   result = inMemData;
            endcase
        end
    end

    // Misalignment only applies to loads; byte loads are always aligned.
    always_comb begin
        misaligned = 1'b0;
        if (inMemToReg) begin
            case (inLoadSize)
                SIZE_HALF: misaligned = inAluResult[0];
                SIZE_BYTE: misaligned = 1'b0;
                default:   misaligned = (inAluResult[1:0] != 2'b00);
            endcase
        end
    end

    assign write_ok = inRegWrite && (inRegAddr != 5'd0) && !flush && !misaligned;

    // Next-state: write pulse, error pulse and counter advance only on a capture.
    always_comb begin
        we_d      = 1'b0;
        align_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        retired_d = retired_q;
        if (capture) begin
            waddr_d = inRegAddr;
            wdata_d = result;
            we_d    = write_ok;
            align_d = misaligned && !flush;
            if (!flush) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    // State registers; reset clears any in-flight write immediately.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            align_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            align_q   <= align_d;
            retired_q <= retired_d;
        end
    end

    assign writeEn      = we_q;
    assign writeAddr    = waddr_q;
    assign writeData    = wdata_q;
    assign alignErr     = align_q;
    assign retiredCount = retired_q;

`ifdef WB_BYPASS_EN
    assign bypassValid = capture && write_ok;
    assign bypassAddr  = inRegAddr;
    assign bypassData  = result;
`else
    assign bypassValid = 1'b0;
    assign bypassAddr  = 5'd0;
    assign bypassData  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, randomized vectors scored
// by an arithmetic reference model, and hand-written reset/wrap sequences.
module tb_writeback_stage;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic        stall;
    logic        flush;
    logic        inRegWrite;
    logic [4:0]  inRegAddr;
    logic        inMemToReg;
    logic [31:0] inAluResult;
    logic [31:0] inMemData;
    logic [1:0]  inLoadSize;
    logic        inLoadUnsigned;
    logic        writeEn;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        alignErr;
    logic [31:0] retiredCount;
    logic        bypassValid;
    logic [4:0]  bypassAddr;
    logic [31:0] bypassData;

    writeback_stage dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .stall(stall), .flush(flush), .inRegWrite(inRegWrite),
        .inRegAddr(inRegAddr), .inMemToReg(inMemToReg),
        .inAluResult(inAluResult), .inMemData(inMemData),
        .inLoadSize(inLoadSize), .inLoadUnsigned(inLoadUnsigned),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .alignErr(alignErr), .retiredCount(retiredCount),
        .bypassValid(bypassValid), .bypassAddr(bypassAddr),
        .bypassData(bypassData)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, stall, flush, rw;
        logic [4:0]  rd;
        logic        m2r;
        logic [31:0] alu, mem;
        logic [1:0]  size;
        logic        uns;
        logic        exp_we, exp_ae;
        logic [31:0] exp_wd;
        logic        exp_inc;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [4:0]  hold_wa = 5'd0;
    logic [31:0] hold_wd = 32'd0;
    vec_t        tbl[$];

    localparam logic [31:0] M  = 32'h80FF7F01;
    localparam logic [1:0]  SW = 2'b00, SH = 2'b01, SB = 2'b10, SR = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, s, f, rw, input logic [4:0] rd,
                                input logic m2r, input logic [31:0] alu, mem,
                                input logic [1:0] size, input logic uns,
                                input logic we, ae, input logic [31:0] wd,
                                input logic inc);
        vec_t r;
        r.valid = v; r.stall = s; r.flush = f; r.rw = rw; r.rd = rd;
        r.m2r = m2r; r.alu = alu; r.mem = mem; r.size = size; r.uns = uns;
        r.exp_we = we; r.exp_ae = ae; r.exp_wd = wd; r.exp_inc = inc;
        return r;
    endfunction

    // Reference model: value a load/ALU op retires, from shifts and masks.
    function automatic logic [31:0] model_result(input vec_t v);
        longint unsigned x;
        if (!v.m2r) return v.alu;
        if (v.size == SB) begin
            x = (longint'(v.mem) >> (8 * int'(v.alu[1:0]))) & 64'hFF;
            if (!v.uns && x >= 128) x = x + 64'hFFFF_FF00;
            return x[31:0];
        end
        if (v.size == SH) begin
            x = (longint'(v.mem) >> (16 * int'(v.alu[1]))) & 64'hFFFF;
            if (!v.uns && x >= 32768) x = x + 64'hFFFF_0000;
            return x[31:0];
        end
        return v.mem;
    endfunction

    function automatic vec_t model_fill(input vec_t v);
        vec_t r = v;
        logic cap, mis;
        cap = v.valid && !v.stall;
        mis = v.m2r && ((v.size == SH && (v.alu % 2) != 0) ||
                        ((v.size == SW || v.size == SR) && (v.alu % 4) != 0));
        r.exp_wd  = model_result(v);
        r.exp_we  = cap && !v.flush && v.rw && (v.rd != 0) && !mis;
        r.exp_ae  = cap && !v.flush && mis;
        r.exp_inc = cap && !v.flush;
        return r;
    endfunction

    // Driver + checker for one cycle; entered and left on a negative edge.
    task automatic apply_vec(input vec_t v, input string tag);
        logic cap;
        inValid = v.valid; stall = v.stall; flush = v.flush; inRegWrite = v.rw;
        inRegAddr = v.rd; inMemToReg = v.m2r; inAluResult = v.alu;
        inMemData = v.mem; inLoadSize = v.size; inLoadUnsigned = v.uns;
        cap = v.valid && !v.stall;
        #1;
        check({tag, " inReady"}, {31'd0, inReady}, {31'd0, !v.stall});
`ifdef WB_BYPASS_EN
        check({tag, " bypassValid"}, {31'd0, bypassValid}, {31'd0, cap && v.exp_we});
        check({tag, " bypassAddr"}, {27'd0, bypassAddr}, {27'd0, v.rd});
        if (cap) check({tag, " bypassData"}, bypassData, v.exp_wd);
`else
        check({tag, " bypass tied"}, {bypassData[31:6], bypassAddr, bypassValid}, 32'd0);
`endif
        if (cap) begin
            hold_wa = v.rd;
            hold_wd = v.exp_wd;
        end
        if (cap && v.exp_inc) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
        check({tag, " writeEn"}, {31'd0, writeEn}, {31'd0, cap && v.exp_we});
        check({tag, " alignErr"}, {31'd0, alignErr}, {31'd0, cap && v.exp_ae});
        check({tag, " writeAddr"}, {27'd0, writeAddr}, {27'd0, hold_wa});
        check({tag, " writeData"}, writeData, hold_wd);
        check({tag, " retiredCount"}, retiredCount, exp_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        inValid = 1'b0; stall = 1'b0; flush = 1'b0; inRegWrite = 1'b0;
        inRegAddr = 5'd0; inMemToReg = 1'b0; inAluResult = 32'd0;
        inMemData = 32'd0; inLoadSize = 2'b00; inLoadUnsigned = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " writeEn"}, {31'd0, writeEn}, 32'd0);
        check({tag, " writeAddr"}, {27'd0, writeAddr}, 32'd0);
        check({tag, " writeData"}, writeData, 32'd0);
        check({tag, " alignErr"}, {31'd0, alignErr}, 32'd0);
        check({tag, " retiredCount"}, retiredCount, 32'd0);
    endtask

    initial begin
        vec_t r;
        idle();
        rstN = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // Directed table: inputs and hand-derived expectations.
        tbl.push_back(mk(1,0,0,1,5'd5, 1,32'h1001,M,SB,0, 1,0,32'h0000007F,1));
        tbl.push_back(mk(1,0,0,1,5'd5, 1,32'h1003,M,SB,0, 1,0,32'hFFFFFF80,1));
        tbl.push_back(mk(1,0,0,1,5'd6, 1,32'h1002,M,SH,1, 1,0,32'h000080FF,1));
        tbl.push_back(mk(1,0,0,1,5'd6, 1,32'h1001,M,SH,1, 0,1,32'h00007F01,1));
        tbl.push_back(mk(1,0,0,1,5'd0, 0,32'h12345678,0,SW,0, 0,0,32'h12345678,1));
        tbl.push_back(mk(1,0,0,1,5'd1, 0,32'h11111111,0,SW,0, 1,0,32'h11111111,1));
        tbl.push_back(mk(1,0,0,1,5'd2, 0,32'h22222222,0,SW,0, 1,0,32'h22222222,1));
        tbl.push_back(mk(1,0,0,1,5'd3, 0,32'h33333333,0,SW,0, 1,0,32'h33333333,1));
        tbl.push_back(mk(1,1,0,1,5'd4, 0,32'hAAAA0000,0,SW,0, 0,0,32'h0,0));
        tbl.push_back(mk(1,0,1,1,5'd4, 0,32'hBBBB0000,0,SW,0, 0,0,32'hBBBB0000,0));
        tbl.push_back(mk(1,1,1,1,5'd4, 0,32'hCCCC0000,0,SW,0, 0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,1,5'd8, 1,32'h2000,M,SW,0, 1,0,M,1));
        tbl.push_back(mk(1,0,0,1,5'd8, 1,32'h2002,M,SW,0, 0,1,M,1));
        tbl.push_back(mk(1,0,0,1,5'd9, 1,32'h2004,M,SR,0, 1,0,M,1));
        tbl.push_back(mk(0,0,0,1,5'd9, 0,32'h0000DDDD,0,SW,0, 0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,1,5'd7, 0,32'hDEADBEEF,0,SW,0, 1,0,32'hDEADBEEF,1));
        tbl.push_back(mk(1,0,0,1,5'd10,1,32'h3003,M,SB,1, 1,0,32'h00000080,1));
        tbl.push_back(mk(1,0,1,1,5'd11,1,32'h3001,M,SH,0, 0,0,32'h00007F01,0));
        tbl.push_back(mk(1,0,0,1,5'd12,1,32'h3002,M,SB,0, 1,0,32'hFFFFFFFF,1));
        tbl.push_back(mk(1,0,0,0,5'd13,1,32'h3000,M,SW,0, 0,0,M,1));
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Randomized vectors scored by the reference model.
        for (int i = 0; i < 300; i++) begin
            r.valid = ($urandom_range(0, 7) != 0);
            r.stall = ($urandom_range(0, 4) == 0);
            r.flush = ($urandom_range(0, 5) == 0);
            r.rw    = ($urandom_range(0, 3) != 0);
            r.rd    = 5'($urandom_range(0, 31));
            r.m2r   = 1'($urandom_range(0, 1));
            r.alu   = $urandom;
            r.mem   = $urandom;
            r.size  = 2'($urandom_range(0, 3));
            r.uns   = 1'($urandom_range(0, 1));
            apply_vec(model_fill(r), $sformatf("rnd%0d", i));
        end

        // Counter wrap: preload all-ones, next retiring capture gives zero.
        idle();
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        exp_cnt = 32'hFFFFFFFF;
        check("wrap preload", retiredCount, exp_cnt);
        apply_vec(mk(1,0,0,1,5'd14,0,32'h0000C0DE,0,SW,0, 1,0,32'h0000C0DE,1), "wrap");
        check("wrap zero", retiredCount, 32'd0);

        // Asynchronous reset in the middle of a write pulse.
        r = mk(1,0,0,1,5'd15,0,32'h5A5A5A5A,0,SW,0, 1,0,32'h5A5A5A5A,1);
        inValid = 1'b1; stall = 1'b0; flush = 1'b0; inRegWrite = 1'b1;
        inRegAddr = r.rd; inMemToReg = 1'b0; inAluResult = r.alu;
        @(posedge clk);
        #2;
        check("pre-reset writeEn", {31'd0, writeEn}, 32'd1);
        rstN = 1'b0;
        #1;
        check_reset_outputs("async reset");
        idle();
        @(negedge clk);
        rstN = 1'b1;
        exp_cnt = 32'd0; hold_wa = 5'd0; hold_wd = 32'd0;
        apply_vec(mk(1,0,0,1,5'd16,0,32'h0BADF00D,0,SW,0, 1,0,32'h0BADF00D,1), "post-reset");

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
